alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared set of registered ALU units.
// One operation in flight: accept, issue one enable pulse, capture the result, hold it until consumed.
module alu_arbiter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [3:0]            req0_fun,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [3:0]            req1_fun,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [1:0]            alu_fun,
  output logic                  arith_enable,
  output logic                  logic_enable,
  output logic                  cmp_enable,
  output logic                  shift_enable,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_flag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_flag,
  output logic                  busy,
  output logic [15:0]           op_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [3:0]            fun_q, fun_d;
  logic                  id_q, id_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_flag_q, rsp_flag_d;
  logic [15:0]           op_count_q, op_count_d;

  logic any_valid;
  logic grant_id;

  assign any_valid = req0_valid | req1_valid;
  // On a tie the requester that did not win last time gets the grant.
  assign grant_id  = (req0_valid && req1_valid) ? ~last_q : req1_valid;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    fun_d        = fun_q;
    id_d         = id_q;
    last_d       = last_q;
    rsp_data_d   = rsp_data_q;
    rsp_flag_d   = rsp_flag_q;
    op_count_d   = op_count_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    arith_enable = 1'b0;
    logic_enable = 1'b0;
    cmp_enable   = 1'b0;
    shift_enable = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A reset in this cycle wins, so no acceptance is signalled alongside it.
        if (any_valid && !rst) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          a_d        = grant_id ? req1_a   : req0_a;
          b_d        = grant_id ? req1_b   : req0_b;
          fun_d      = grant_id ? req1_fun : req0_fun;
          id_d       = grant_id;
          last_d     = grant_id;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        case (fun_q[3:2])
          2'b00: arith_enable = 1'b1;
          2'b01: logic_enable = 1'b1;
          2'b10: cmp_enable   = 1'b1;
          2'b11: shift_enable = 1'b1;
        endcase
        state_d = CAPTURE;
      end
      CAPTURE: begin
        rsp_data_d = alu_out;
        rsp_flag_d = alu_flag;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      fun_q      <= '0;
      id_q       <= 1'b0;
      last_q     <= 1'b1;
      rsp_data_q <= '0;
      rsp_flag_q <= 1'b0;
      op_count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      fun_q      <= fun_d;
      id_q       <= id_d;
      last_q     <= last_d;
      rsp_data_q <= rsp_data_d;
      rsp_flag_q <= rsp_flag_d;
      op_count_q <= op_count_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_fun   = fun_q[1:0];
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flag  = rsp_flag_q;
  assign busy      = (state_q != IDLE);
  assign op_count  = op_count_q;

endmodule
